// File: rtl/pc_if.sv
// Control-unit to PC-unit bus: next-PC request fields and PC/RAS/exception status.
interface pc_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic                    ena;
  logic [2:0]              sel;
  logic signed [WIDTH-1:0] br_off;
  logic [WIDTH-1:0]        target;
  logic                    exc;
  logic                    eret;
  logic [WIDTH-1:0]        pc_out;
  logic [WIDTH-1:0]        epc_out;
  logic                    in_exc;
  logic [CNT_W-1:0]        ras_count;
  logic                    ras_underflow;
  logic                    misalign;

  modport master (
    output ena, sel, br_off, target, exc, eret,
    input  pc_out, epc_out, in_exc, ras_count, ras_underflow, misalign
  );

  modport slave (
    input  ena, sel, br_off, target, exc, eret,
    output pc_out, epc_out, in_exc, ras_count, ras_underflow, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC unit with next-PC select, circular return-address stack and exception/eret.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(4),
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_CALL = 3'd3;
  localparam logic [2:0] SEL_RET  = 3'd4;

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);

  function automatic logic [WIDTH-1:0] br_dest(input logic [WIDTH-1:0] pc,
                                               input logic signed [WIDTH-1:0] off);
    // Two's-complement add; wrap modulo 2^WIDTH is intentional.
    return pc + $unsigned(off);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_PTR : p - PTR_W'(1);
  endfunction

`ifdef PC_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [WIDTH-1:0] a);
    return (a & (STEP_V - WIDTH'(1))) != '0;
  endfunction
`endif

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_exc_q, in_exc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic             uf_q, uf_d;
  logic             push, pop, take_exc;
  logic [WIDTH-1:0] seq_pc, ras_top;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
`ifdef PC_ALIGN_CHECK_EN
  logic             mis_q, mis_d;
`endif

  // ptr_q addresses the next free slot; the newest entry sits just below it.
  assign seq_pc  = pc_q + STEP_V;
  assign ras_top = ras_mem[ptr_dec(ptr_q)];

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    uf_d     = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    take_exc = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d    = 1'b0;
`endif
    if (bus.exc) begin
      take_exc = 1'b1;
    end else if (bus.eret && in_exc_q) begin
      pc_d     = epc_q;
      in_exc_d = 1'b0;
    end else if (bus.ena) begin
      case (bus.sel)
        SEL_BR:   pc_d = br_dest(pc_q, bus.br_off);
        SEL_JMP:  pc_d = bus.target;
        SEL_CALL: begin
          pc_d = bus.target;
          push = 1'b1;
        end
        SEL_RET: begin
          if (cnt_q != '0) begin
            pc_d = ras_top;
            pop  = 1'b1;
          end else begin
            pc_d = bus.target;
            uf_d = 1'b1;
          end
        end
        default:  pc_d = seq_pc;
      endcase
`ifdef PC_ALIGN_CHECK_EN
      // A misaligned redirect becomes an exception; a CALL must not leave a stale push.
      if ((bus.sel inside {SEL_BR, SEL_JMP, SEL_CALL, SEL_RET}) && misaligned(pc_d)) begin
        take_exc = 1'b1;
        mis_d    = 1'b1;
        push     = 1'b0;
      end
`endif
    end
    // Nested exceptions re-vector but keep the EPC of the first one.
    if (take_exc) begin
      pc_d     = EXC_VEC;
      in_exc_d = 1'b1;
      if (!in_exc_q) epc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      uf_q     <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      uf_q     <= uf_d;
`ifdef PC_ALIGN_CHECK_EN
      mis_q    <= mis_d;
`endif
      if (push) begin
        ptr_q <= ptr_inc(ptr_q);
        if (cnt_q != FULL_CNT) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        ptr_q <= ptr_dec(ptr_q);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Stack storage carries no reset; validity is tracked solely by cnt_q.
  always_ff @(posedge clk) begin
    if (push && !rst) ras_mem[ptr_q] <= seq_pc;
  end

  assign bus.pc_out        = pc_q;
  assign bus.epc_out       = epc_q;
  assign bus.in_exc        = in_exc_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_underflow = uf_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign      = mis_q;
`else
  assign bus.misalign      = 1'b0;
`endif

endmodule
